muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40: max cycles the arithmetic unit may run before abort.
REQ-002 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  one-cycle request from the CPU control FSM to begin an operation.
REQ-005 SHALL have port op  in  1  operation select sampled with start: 0 = MULT, 1 = DIV.
REQ-006 SHALL have ports a_in, b_in  in  32 each  operands sampled with start.
REQ-007 SHALL have port hilo_rd  in  1  CPU wants HI/LO this cycle (MFHI/MFLO).
REQ-008 SHALL have ports unit_a, unit_b  out  32 each  latched operands driven to the unit.
REQ-009 SHALL have port unit_sel  out  1  0 = multiplier, 1 = divider.
REQ-010 SHALL have port unit_go  out  1  one-cycle start pulse to the selected unit.
REQ-011 SHALL have ports unit_done  in  1, unit_hi / unit_lo  in  32 each  completion and result from the selected unit.
REQ-012 SHALL have ports hi, lo  out  32 each  architectural HI/LO registers.
REQ-013 SHALL have ports busy  out  1, stall  out  1, done  out  1, div_zero  out  1, timeout_err  out  1.

Function
REQ-014 SHALL implement states IDLE, LAUNCH, RUN, WRITE, EXC.
REQ-015 IDLE: on start SHALL latch op, a_in, b_in into unit_sel, unit_a, unit_b; go to EXC if op=1 and b_in=0, else LAUNCH.
REQ-016 start while not IDLE SHALL be ignored; no queuing.
REQ-017 LAUNCH SHALL assert unit_go for exactly one cycle, clear cycle counter, go to RUN.
REQ-018 RUN SHALL increment the counter each cycle; unit_done=1 goes to WRITE, capturing unit_hi/unit_lo into internal result registers that same cycle.
REQ-019 If counter reaches TIMEOUT with unit_done=0, SHALL go to EXC with timeout_err cause; unit_done in the same cycle as the limit takes priority (WRITE).
REQ-020 WRITE SHALL copy captured results into hi/lo, pulse done for one cycle, return to IDLE.
REQ-021 EXC SHALL pulse div_zero (B=0 cause) or timeout_err (timeout cause) for one cycle, leave hi/lo unchanged, return to IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 stall SHALL equal hilo_rd AND busy, combinationally; hilo_rd in IDLE never stalls.
REQ-024 Latency start-to-done for a unit completing k cycles after unit_go SHALL be k+3 cycles (IDLE->LAUNCH->RUN...->WRITE).
REQ-025 unit_done outside RUN SHALL be ignored.
REQ-026 hi/lo SHALL change only in WRITE; partial results never visible.
REQ-027 Counter SHALL be wide enough for TIMEOUT without wrap (clog2(TIMEOUT)+1 bits).

Reset
REQ-028 Reset SHALL force state IDLE, hi=lo=0, unit_a=unit_b=0, unit_sel=0, counter=0, all pulse outputs 0.
REQ-029 Reset mid-operation SHALL abort without done/error pulse and without updating hi/lo; a unit_done arriving afterwards SHALL be ignored.
REQ-030 Reset SHALL take priority over start in the same cycle.

Structure
REQ-031 State encoding, OP_MULT/OP_DIV constants and default TIMEOUT SHALL live in shared package muldiv_pkg.
REQ-032 Timeout counter SHALL be the single sub-module muldiv_watchdog (clear, enable, expired).
REQ-033 The existing multiplier and divider SHALL stay outside this block, reached only through the unit_* ports.

Verification
REQ-034 DIV a=100, b=7, unit model done after 32 cycles with hi=2, lo=14 -> done at start+35, hi=2, lo=14, busy low the next cycle.
REQ-035 DIV a=5, b=0 -> unit_go never asserted, div_zero pulse one cycle after start, hi/lo unchanged.
REQ-036 MULT with unit model never completing, TIMEOUT=40 -> timeout_err pulse once, hi/lo unchanged, IDLE after.
REQ-037 hilo_rd held high during a MULT -> stall high exactly while busy, low the cycle after done.
REQ-038 Reset at RUN cycle 10, then unit_done -> no done, hi=lo=0, IDLE; second start during RUN ignored.
REQ-039 unit_done coincident with counter reaching TIMEOUT -> done pulse and results written, no timeout_err.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MULT/DIV sequencing controller.
// Holds the FSM state encoding, operation codes and default watchdog limit.
package muldiv_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned TIMEOUT_DEFAULT = 40;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_WRITE  = 3'd3,
    ST_EXC    = 3'd4
  } state_t;

  typedef enum logic {
    EXC_DIV_ZERO = 1'b0,
    EXC_TIMEOUT  = 1'b1
  } exc_cause_t;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

endpackage

// File: rtl/muldiv_if.sv
// Link between the controller and the external multiplier/divider units.
// The controller is the master: it drives operands and the go pulse.
interface muldiv_if;
  import muldiv_pkg::*;

  logic [DATA_W-1:0] unit_a;
  logic [DATA_W-1:0] unit_b;
  logic              unit_sel;
  logic              unit_go;
  logic              unit_done;
  logic [DATA_W-1:0] unit_hi;
  logic [DATA_W-1:0] unit_lo;

  modport master (
    output unit_a, unit_b, unit_sel, unit_go,
    input  unit_done, unit_hi, unit_lo
  );

  modport slave (
    input  unit_a, unit_b, unit_sel, unit_go,
    output unit_done, unit_hi, unit_lo
  );

endinterface

// File: rtl/muldiv_watchdog.sv
// Cycle counter bounding how long an arithmetic unit may run.
// expired flags the LIMIT-th enabled cycle so the caller can abort on it.
module muldiv_watchdog
  import muldiv_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT) + 1;

  logic [CNT_W-1:0] count;

  // Holds at the limit rather than wrapping.
  always_ff @(posedge clk) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequences MULT/DIV requests onto the external units and owns the HI/LO registers.
// Detects divide-by-zero up front and aborts units that overrun the watchdog.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              hilo_rd,
  muldiv_if.master          unit,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic              div_zero,
  output logic              timeout_err
);

  state_t            state, state_nx;
  exc_cause_t        cause, cause_nx;
  hilo_t             res, res_nx;
  logic [DATA_W-1:0] a_nx, b_nx, hi_nx, lo_nx;
  logic              sel_nx, go_nx, done_nx, dz_nx, to_nx, busy_nx;
  logic              wd_clear, wd_enable, wd_expired;

  assign wd_clear  = (state == ST_LAUNCH);
  assign wd_enable = (state == ST_RUN);

  muldiv_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .Reset   (Reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // unit_done wins over the watchdog when both land in the same cycle.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ((op == OP_DIV) && (b_in == '0)) ? ST_EXC : ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_nx = ST_RUN;
      ST_RUN: begin
        if (unit.unit_done) begin
          state_nx = ST_WRITE;
        end else if (wd_expired) begin
          state_nx = ST_EXC;
        end
      end
      ST_WRITE: state_nx = ST_IDLE;
      ST_EXC:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Next values for every registered output, derived from the transition taken.
  always_comb begin
    a_nx     = unit.unit_a;
    b_nx     = unit.unit_b;
    sel_nx   = unit.unit_sel;
    cause_nx = cause;
    res_nx   = res;
    hi_nx    = hi;
    lo_nx    = lo;
    case (state)
      ST_IDLE: begin
        if (start) begin
          a_nx     = a_in;
          b_nx     = b_in;
          sel_nx   = op;
          cause_nx = EXC_DIV_ZERO;
        end
      end
      ST_RUN: begin
        if (unit.unit_done) begin
          res_nx = '{hi: unit.unit_hi, lo: unit.unit_lo};
        end else if (wd_expired) begin
          cause_nx = EXC_TIMEOUT;
        end
      end
      default: ;
    endcase
    if (state_nx == ST_WRITE) begin
      hi_nx = res_nx.hi;
      lo_nx = res_nx.lo;
    end
    go_nx   = (state_nx == ST_LAUNCH);
    done_nx = (state_nx == ST_WRITE);
    dz_nx   = (state_nx == ST_EXC) && (cause_nx == EXC_DIV_ZERO);
    to_nx   = (state_nx == ST_EXC) && (cause_nx == EXC_TIMEOUT);
    busy_nx = (state_nx != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      unit.unit_a   <= '0;
      unit.unit_b   <= '0;
      unit.unit_sel <= 1'b0;
      unit.unit_go  <= 1'b0;
      cause         <= EXC_DIV_ZERO;
      res           <= '0;
      hi            <= '0;
      lo            <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      div_zero      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      unit.unit_a   <= a_nx;
      unit.unit_b   <= b_nx;
      unit.unit_sel <= sel_nx;
      unit.unit_go  <= go_nx;
      cause         <= cause_nx;
      res           <= res_nx;
      hi            <= hi_nx;
      lo            <= lo_nx;
      busy          <= busy_nx;
      done          <= done_nx;
      div_zero      <= dz_nx;
      timeout_err   <= to_nx;
    end
  end

  assign stall = hilo_rd & busy;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed scenarios then random traffic,
// compared cycle by cycle against a transaction-level timeline model.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int TO     = int'(TIMEOUT_DEFAULT);
  localparam int K_DONE = 0;
  localparam int K_DZ   = 1;
  localparam int K_TO   = 2;

  logic        clk = 1'b0;
  logic        Reset, start, op, hilo_rd;
  logic [31:0] a_in, b_in, hi, lo;
  logic        busy, stall, done, div_zero, timeout_err;

  muldiv_if u_if ();

  muldiv_ctrl #(.TIMEOUT(TIMEOUT_DEFAULT)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .start       (start),
    .op          (op),
    .a_in        (a_in),
    .b_in        (b_in),
    .hilo_rd     (hilo_rd),
    .unit        (u_if),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .div_zero    (div_zero),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks, n_errors, cyc;

  // Timeline model: one transaction at a time, described by start/end cycle and outcome.
  bit          valid, act;
  int          t_s, t_e, kind, rst_cyc;
  logic [31:0] r_hi, r_lo, arch_hi, arch_lo, e_a, e_b;
  logic        e_sel;

  // Unit model: answers k clocks after it samples unit_go (k < 0 means never).
  bit          u_pending;
  int          u_k, u_fire;
  logic [31:0] u_hi, u_lo;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit st_in, input bit op_i, input logic [31:0] av, input logic [31:0] bv,
                      input int kv, input bit rd, input bit rst);
    bit          busy_e, in_run, st, just_reset, go_e;
    logic [63:0] prod;
    just_reset = (rst_cyc == cyc - 1);
    if (just_reset) begin
      act = 1'b0; arch_hi = '0; arch_lo = '0; valid = 1'b1;
    end
    if (act && kind == K_DONE && cyc == t_e) begin
      arch_hi = r_hi; arch_lo = r_lo;
    end
    busy_e = act && cyc > t_s && cyc <= t_e;
    in_run = act && kind != K_DZ && cyc >= t_s + 2 && cyc < t_e;
    go_e   = act && kind != K_DZ && cyc == t_s + 1;
    st     = st_in;
    if (u_pending && !busy_e) st = 1'b0;   // never launch while a stale unit answer is in flight

    Reset = rst; start = st; op = op_i; a_in = av; b_in = bv; hilo_rd = rd;
    u_if.unit_done = 1'b0; u_if.unit_hi = $urandom; u_if.unit_lo = $urandom;
    if (u_pending && cyc == u_fire) begin
      u_if.unit_done = 1'b1; u_if.unit_hi = u_hi; u_if.unit_lo = u_lo; u_pending = 1'b0;
    end else if (!u_pending && !in_run && ($urandom % 8) == 0) begin
      u_if.unit_done = 1'b1;
    end

    if (st && !rst && !busy_e && valid) begin
      act = 1'b1; t_s = cyc; u_k = kv; e_a = av; e_b = bv; e_sel = op_i;
      if (op_i && bv == 0) begin
        kind = K_DZ; t_e = cyc + 1;
      end else if (kv >= 0 && kv + 1 <= TO) begin
        kind = K_DONE; t_e = cyc + kv + 3;
        if (op_i) begin
          r_lo = av / bv; r_hi = av % bv;
        end else begin
          prod = 64'(av) * 64'(bv); r_hi = prod[63:32]; r_lo = prod[31:0];
        end
      end else begin
        kind = K_TO; t_e = cyc + TO + 2;
      end
      go_e = 1'b0;
    end
    if (rst) rst_cyc = cyc;

    @(negedge clk);
    if (valid) begin
      chk("busy",        64'(busy),        64'(busy_e));
      chk("done",        64'(done),        64'(act && kind == K_DONE && cyc == t_e));
      chk("div_zero",    64'(div_zero),    64'(act && kind == K_DZ && cyc == t_e));
      chk("timeout_err", 64'(timeout_err), 64'(act && kind == K_TO && cyc == t_e));
      chk("unit_go",     64'(u_if.unit_go), 64'(go_e));
      chk("stall",       64'(stall),       64'(rd && busy_e));
      chk("hi",          64'(hi),          64'(arch_hi));
      chk("lo",          64'(lo),          64'(arch_lo));
      if (act && cyc == t_s + 1) begin
        chk("unit_a",   64'(u_if.unit_a),   64'(e_a));
        chk("unit_b",   64'(u_if.unit_b),   64'(e_b));
        chk("unit_sel", 64'(u_if.unit_sel), 64'(e_sel));
      end
      if (just_reset) begin
        chk("rst_unit_a",   64'(u_if.unit_a),   64'(0));
        chk("rst_unit_b",   64'(u_if.unit_b),   64'(0));
        chk("rst_unit_sel", 64'(u_if.unit_sel), 64'(0));
      end
    end
    if (u_if.unit_go === 1'b1 && u_k >= 0) begin
      u_pending = 1'b1;
      u_fire    = cyc + 1 + u_k;
      if (u_if.unit_sel) begin
        u_lo = (u_if.unit_b != 0) ? u_if.unit_a / u_if.unit_b : '0;
        u_hi = (u_if.unit_b != 0) ? u_if.unit_a % u_if.unit_b : '0;
      end else begin
        prod = 64'(u_if.unit_a) * 64'(u_if.unit_b);
        u_hi = prod[63:32]; u_lo = prod[31:0];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit rd);
    repeat (n) step(1'b0, 1'b0, $urandom, $urandom, 0, rd, 1'b0);
  endtask

  initial begin
    bit          ro;
    int          rk, rsel;
    logic [31:0] ra, rb;
    n_checks = 0; n_errors = 0; cyc = 0; rst_cyc = -100;
    valid = 1'b0; act = 1'b0; t_s = -100; t_e = -100; kind = K_DONE;
    arch_hi = '0; arch_lo = '0; u_pending = 1'b0; u_k = -1; u_fire = -1;
    Reset = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0; hilo_rd = 1'b0;
    u_if.unit_done = 1'b0; u_if.unit_hi = '0; u_if.unit_lo = '0;
    #1;
    repeat (3) step(1'b0, 1'b0, '0, '0, 0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // DIV 100/7, unit answers after 32 cycles
    step(1'b1, OP_DIV, 32'd100, 32'd7, 32, 1'b0, 1'b0);
    idle(40, 1'b0);
    // DIV by zero
    step(1'b1, OP_DIV, 32'd5, 32'd0, 5, 1'b0, 1'b0);
    idle(4, 1'b0);
    // MULT that never completes
    step(1'b1, OP_MULT, 32'h0001_0003, 32'h0002_0005, -1, 1'b0, 1'b0);
    idle(TO + 5, 1'b0);
    // MULT with hilo_rd held high
    step(1'b1, OP_MULT, 32'hFFFF_FFFF, 32'h0000_0003, 6, 1'b1, 1'b0);
    idle(12, 1'b1);
    // Reset in RUN cycle 10, second start ignored, late unit_done ignored
    step(1'b1, OP_MULT, 32'h1234, 32'h55, 20, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) step(i == 5, OP_DIV, 32'd9, 32'd3, 3, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, '0, 0, 1'b0, 1'b1);
    idle(25, 1'b0);
    // unit_done on the limit cycle, then one cycle past it
    step(1'b1, OP_MULT, 32'h0BAD_F00D, 32'h0000_0101, TO - 1, 1'b0, 1'b0);
    idle(TO + 5, 1'b0);
    step(1'b1, OP_DIV, 32'd1000, 32'd33, TO, 1'b0, 1'b0);
    idle(TO + 5, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      ro   = ($urandom % 2) == 1;
      ra   = $urandom;
      rb   = $urandom;
      rsel = int'($urandom % 16);
      if (ro && ($urandom % 5) == 0) rb = '0;
      if (rsel == 0)      rk = -1;
      else if (rsel == 1) rk = TO - 1;
      else if (rsel == 2) rk = TO;
      else                rk = int'($urandom % 12);
      step(($urandom % 3) == 0, ro, ra, rb, rk, ($urandom % 2) == 1, ($urandom % 400) == 0);
    end
    idle(TO + 5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
